// File: rtl/lcd_nibble_writer.sv
// lcd_nibble_writer - 4-bit HD44780 character LCD output stage.
// Runs the power-on init nibbles and the configuration command bytes. It then
// sends one accepted data byte at a time as two timed nibbles, and reports
// readiness so the upstream ALU can stall.
// Optional feature: define LCD_AUTO_WRAP_EN to track the cursor. With it, the
// block emits line-2 (0xC0) and line-1 (0x80) commands after the 16th and 32nd
// characters.
module lcd_nibble_writer #(
    parameter int unsigned T_POWERUP    = 750000,
    parameter int unsigned T_4100US     = 205000,
    parameter int unsigned T_100US      = 5000,
    parameter int unsigned T_40US       = 2000,
    parameter int unsigned T_1640US     = 82000,
    parameter int unsigned T_SETUP      = 2,
    parameter int unsigned T_E_HIGH     = 12,
    parameter int unsigned T_NIBBLE_GAP = 50
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       iWriteEnable,
    input  logic [7:0] iData,
    output logic       oLCD_E,
    output logic       oLCD_RS,
    output logic       oLCD_RW,
    output logic       oLCD_StrataFlashControl,
    output logic [3:0] oLCD_Data,
    output logic       oIsInitialized,
    output logic       oReady
);

    // Down-counter reload values: a wait of N cycles loads N-1 and expires at 0.
    localparam logic [19:0] C_POWERUP = 20'(T_POWERUP - 1);
    localparam logic [19:0] C_4100US  = 20'(T_4100US - 1);
    localparam logic [19:0] C_100US   = 20'(T_100US - 1);
    localparam logic [19:0] C_40US    = 20'(T_40US - 1);
    localparam logic [19:0] C_1640US  = 20'(T_1640US - 1);
    localparam logic [19:0] C_SETUP   = 20'(T_SETUP - 1);
    localparam logic [19:0] C_E_HIGH  = 20'(T_E_HIGH - 1);
    localparam logic [19:0] C_GAP     = 20'(T_NIBBLE_GAP - 1);

    typedef enum logic [2:0] {
        TOP_PWRUP,
        TOP_INIT,
        TOP_CONFIG,
        TOP_IDLE,
        TOP_XFER,
        TOP_WRAP
    } top_t;

    // Per-nibble phases; START only exists to give data writes their one-cycle
    // latch-to-drive step after acceptance.
    typedef enum logic [2:0] {
        SUB_START,
        SUB_SETUP,
        SUB_EHIGH,
        SUB_GAP,
        SUB_WAIT
    } sub_t;

    top_t        r_top;
    sub_t        r_sub;
    logic [19:0] r_cnt;
    logic [1:0]  r_idx;
    logic        r_upper;
    logic [7:0]  r_byte;
    logic        r_e;
    logic        r_rs;
    logic [3:0]  r_data;
    logic        r_init_done;
    logic        r_ready;
    logic [7:0]  w_next_cfg;

    // Init nibble list: 3, 3, 3, 2.
    function automatic logic [3:0] f_init_nib(input logic [1:0] idx);
        return (idx == 2'd3) ? 4'h2 : 4'h3;
    endfunction

    // Configuration commands: function set, entry mode, display on, clear.
    function automatic logic [7:0] f_cfg_byte(input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = 8'h28;
            2'd1:    b = 8'h06;
            2'd2:    b = 8'h0C;
            default: b = 8'h01;
        endcase
        return b;
    endfunction

    // Wait that follows the item just finished in the given top-level state.
    function automatic logic [19:0] f_post_wait(input top_t top, input logic [1:0] idx);
        logic [19:0] w;
        w = C_40US;
        if (top == TOP_INIT) begin
            case (idx)
                2'd0:    w = C_4100US;
                2'd1:    w = C_100US;
                default: w = C_40US;
            endcase
        end else if (top == TOP_CONFIG && idx == 2'd3) begin
            w = C_1640US;
        end
        return w;
    endfunction

    // Index wraps from 3 to 0, which also yields the first config byte when
    // leaving INIT.
    assign w_next_cfg = f_cfg_byte(r_idx + 2'd1);

`ifdef LCD_AUTO_WRAP_EN
    logic [4:0] r_cursor;
    logic       w_wrap_due;
    logic [7:0] w_wrap_cmd;

    // Cursor value is checked after the increment, so 0 means the 32nd character.
    assign w_wrap_due = (r_cursor == 5'd16) || (r_cursor == 5'd0);
    assign w_wrap_cmd = (r_cursor == 5'd16) ? 8'hC0 : 8'h80;
`endif

    // Sequencer: top-level flow, nibble timing, handshake and LCD pins.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_top       <= TOP_PWRUP;
            r_sub       <= SUB_SETUP;
            r_cnt       <= C_POWERUP;
            r_idx       <= 2'd0;
            r_upper     <= 1'b0;
            r_byte      <= 8'h00;
            r_e         <= 1'b0;
            r_rs        <= 1'b0;
            r_data      <= 4'h0;
            r_init_done <= 1'b0;
            r_ready     <= 1'b0;
`ifdef LCD_AUTO_WRAP_EN
            r_cursor    <= 5'd0;
`endif
        end else if (r_top == TOP_PWRUP) begin
            if (r_cnt != 20'd0) begin
                r_cnt <= r_cnt - 20'd1;
            end else begin
                r_top   <= TOP_INIT;
                r_idx   <= 2'd0;
                r_rs    <= 1'b0;
                r_data  <= f_init_nib(2'd0);
                r_upper <= 1'b0;
                r_sub   <= SUB_SETUP;
                r_cnt   <= C_SETUP;
            end
        end else if (r_top == TOP_IDLE) begin
            if (iWriteEnable) begin
                r_byte  <= iData;
                r_ready <= 1'b0;
                r_top   <= TOP_XFER;
                r_sub   <= SUB_START;
`ifdef LCD_AUTO_WRAP_EN
                r_cursor <= r_cursor + 5'd1;
`endif
            end
        end else begin
            case (r_sub)
                SUB_START: begin
                    r_rs    <= 1'b1;
                    r_data  <= r_byte[7:4];
                    r_upper <= 1'b1;
                    r_sub   <= SUB_SETUP;
                    r_cnt   <= C_SETUP;
                end
                SUB_SETUP: begin
                    if (r_cnt != 20'd0) begin
                        r_cnt <= r_cnt - 20'd1;
                    end else begin
                        r_e   <= 1'b1;
                        r_sub <= SUB_EHIGH;
                        r_cnt <= C_E_HIGH;
                    end
                end
                SUB_EHIGH: begin
                    if (r_cnt != 20'd0) begin
                        r_cnt <= r_cnt - 20'd1;
                    end else begin
                        r_e <= 1'b0;
                        if (r_upper) begin
                            r_sub <= SUB_GAP;
                            r_cnt <= C_GAP;
                        end else begin
                            r_sub <= SUB_WAIT;
                            r_cnt <= f_post_wait(r_top, r_idx);
                        end
                    end
                end
                SUB_GAP: begin
                    if (r_cnt != 20'd0) begin
                        r_cnt <= r_cnt - 20'd1;
                    end else begin
                        r_data  <= r_byte[3:0];
                        r_upper <= 1'b0;
                        r_sub   <= SUB_SETUP;
                        r_cnt   <= C_SETUP;
                    end
                end
                default: begin
                    if (r_cnt != 20'd0) begin
                        r_cnt <= r_cnt - 20'd1;
                    end else begin
                        case (r_top)
                            TOP_INIT: begin
                                r_rs  <= 1'b0;
                                r_sub <= SUB_SETUP;
                                r_cnt <= C_SETUP;
                                if (r_idx != 2'd3) begin
                                    r_idx   <= r_idx + 2'd1;
                                    r_data  <= f_init_nib(r_idx + 2'd1);
                                    r_upper <= 1'b0;
                                end else begin
                                    r_top   <= TOP_CONFIG;
                                    r_idx   <= 2'd0;
                                    r_byte  <= w_next_cfg;
                                    r_data  <= w_next_cfg[7:4];
                                    r_upper <= 1'b1;
                                end
                            end
                            TOP_CONFIG: begin
                                if (r_idx != 2'd3) begin
                                    r_idx   <= r_idx + 2'd1;
                                    r_byte  <= w_next_cfg;
                                    r_rs    <= 1'b0;
                                    r_data  <= w_next_cfg[7:4];
                                    r_upper <= 1'b1;
                                    r_sub   <= SUB_SETUP;
                                    r_cnt   <= C_SETUP;
`ifdef LCD_AUTO_WRAP_EN
                                    if (r_idx == 2'd2) begin
                                        r_cursor <= 5'd0;
                                    end
`endif
                                end else begin
                                    r_top       <= TOP_IDLE;
                                    r_init_done <= 1'b1;
                                    r_ready     <= 1'b1;
                                end
                            end
`ifdef LCD_AUTO_WRAP_EN
                            TOP_XFER: begin
                                if (w_wrap_due) begin
                                    r_top   <= TOP_WRAP;
                                    r_byte  <= w_wrap_cmd;
                                    r_rs    <= 1'b0;
                                    r_data  <= w_wrap_cmd[7:4];
                                    r_upper <= 1'b1;
                                    r_sub   <= SUB_SETUP;
                                    r_cnt   <= C_SETUP;
                                end else begin
                                    r_top   <= TOP_IDLE;
                                    r_ready <= 1'b1;
                                end
                            end
`endif
                            default: begin
                                r_top   <= TOP_IDLE;
                                r_ready <= 1'b1;
                            end
                        endcase
                    end
                end
            endcase
        end
    end

    assign oLCD_E                  = r_e;
    assign oLCD_RS                 = r_rs;
    assign oLCD_RW                 = 1'b0;
    assign oLCD_StrataFlashControl = 1'b1;
    assign oLCD_Data               = r_data;
    assign oIsInitialized          = r_init_done;
    assign oReady                  = r_ready;

endmodule

// File: tb/tb_lcd_nibble_writer.sv
// Bench for lcd_nibble_writer with delays scaled down by 1000.
module tb_lcd_nibble_writer;

    localparam int TP    = 750;
    localparam int T41   = 205;
    localparam int T100  = 5;
    localparam int T40   = 2;
    localparam int T1640 = 82;
    localparam int TS    = 2;
    localparam int TE    = 12;
    localparam int TG    = 5;
    localparam int LAT   = 1 + 2 * (TS + TE) + TG + T40;
`ifdef LCD_AUTO_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif

    logic       Clock = 1'b0;
    logic       Reset = 1'b1;
    logic       iWriteEnable = 1'b0;
    logic [7:0] iData = 8'h00;
    logic       oLCD_E, oLCD_RS, oLCD_RW, oLCD_StrataFlashControl;
    logic [3:0] oLCD_Data;
    logic       oIsInitialized, oReady;

    lcd_nibble_writer #(
        .T_POWERUP(TP), .T_4100US(T41), .T_100US(T100), .T_40US(T40),
        .T_1640US(T1640), .T_SETUP(TS), .T_E_HIGH(TE), .T_NIBBLE_GAP(TG)
    ) dut (
        .Clock(Clock), .Reset(Reset), .iWriteEnable(iWriteEnable), .iData(iData),
        .oLCD_E(oLCD_E), .oLCD_RS(oLCD_RS), .oLCD_RW(oLCD_RW),
        .oLCD_StrataFlashControl(oLCD_StrataFlashControl), .oLCD_Data(oLCD_Data),
        .oIsInitialized(oIsInitialized), .oReady(oReady)
    );

    always #5 Clock = ~Clock;

    int cyc = 0;
    always @(posedge Clock) cyc <= cyc + 1;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input int got, input int expv);
        n_chk++;
        if (got !== expv) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, expv, cyc);
        end
    endtask

    task automatic tick();
        @(negedge Clock);
        #1;
    endtask

    // Observed E pulses on the LCD bus.
    typedef struct { logic rs; logic [3:0] nib; int rise; int fall; } pulse_t;
    pulse_t obs[$];
    pulse_t cur;
    logic   prev_e = 1'b0;
    logic [4:0] prev_bus = 5'd0;
    int     last_chg = 0;
    int     setup_short = 0;
    int     bus_in_e = 0;

    always @(negedge Clock) begin
        if ({oLCD_RS, oLCD_Data} != prev_bus) begin
            if (oLCD_E && prev_e) bus_in_e++;
            last_chg = cyc;
        end
        if (oLCD_E && !prev_e) begin
            cur.rs   = oLCD_RS;
            cur.nib  = oLCD_Data;
            cur.rise = cyc;
            if (cyc - last_chg < TS) setup_short++;
        end
        if (!oLCD_E && prev_e) begin
            cur.fall = cyc;
            obs.push_back(cur);
        end
        prev_e   = oLCD_E;
        prev_bus = {oLCD_RS, oLCD_Data};
    end

    // Reference: expected pulse list built from the protocol rules.
    // pre = rise minus previous fall (-1: unchecked); abs_rise = absolute rise cycle (-1: unchecked).
    typedef struct { logic rs; logic [3:0] nib; int pre; int abs_rise; } exp_t;
    exp_t expq[$];
    int   nchar = 0;

    task automatic exp_nib(input logic rs, input logic [3:0] n, input int pre, input int abs_rise);
        exp_t e;
        e.rs = rs; e.nib = n; e.pre = pre; e.abs_rise = abs_rise;
        expq.push_back(e);
    endtask

    task automatic exp_byte(input logic rs, input logic [7:0] b, input int pre, input int abs_rise);
        exp_nib(rs, b[7:4], pre, abs_rise);
        exp_nib(rs, b[3:0], TG + TS, -1);
    endtask

    task automatic match_pulses(input string tag);
        chk({tag, "_count"}, obs.size(), expq.size());
        for (int i = 0; i < obs.size() && i < expq.size(); i++) begin
            chk({tag, "_rs"}, 32'(obs[i].rs), 32'(expq[i].rs));
            chk({tag, "_nib"}, 32'(obs[i].nib), 32'(expq[i].nib));
            chk({tag, "_ehigh"}, obs[i].fall - obs[i].rise, TE);
            if (expq[i].pre >= 0 && i > 0)
                chk({tag, "_spacing"}, obs[i].rise - obs[i-1].fall, expq[i].pre);
            if (expq[i].abs_rise >= 0)
                chk({tag, "_start"}, obs[i].rise, expq[i].abs_rise);
        end
        obs.delete();
        expq.delete();
    endtask

    // Reset, release, and follow the whole init/config sequence while
    // iWriteEnable is asserted with junk data (it must be ignored).
    task automatic do_init();
        int rel, guard, busy_flag, d;
        Reset = 1'b1;
        iWriteEnable = 1'b0;
        tick(); tick();
        chk("rst_e", 32'(oLCD_E), 0);
        chk("rst_rs", 32'(oLCD_RS), 0);
        chk("rst_rw", 32'(oLCD_RW), 0);
        chk("rst_sf", 32'(oLCD_StrataFlashControl), 1);
        chk("rst_data", 32'(oLCD_Data), 0);
        chk("rst_init", 32'(oIsInitialized), 0);
        chk("rst_ready", 32'(oReady), 0);
        obs.delete();
        expq.delete();
        nchar = 0;
        Reset = 1'b0;
        rel = cyc;
        busy_flag = 0;
        guard = 0;
        while (obs.size() < 12 && guard < 5000) begin
            iWriteEnable = 1'($urandom_range(0, 1));
            iData = 8'($urandom);
            tick();
            if (oReady || oIsInitialized) busy_flag++;
            guard++;
        end
        iWriteEnable = 1'b0;
        chk("init_nibbles_seen", 32'(obs.size() >= 12), 1);
        chk("ready_during_init", busy_flag, 0);
        if (obs.size() > 0) begin
            d = obs[0].rise - rel;
            chk("pwrup_wait", 32'(d >= TP + TS - 1 && d <= TP + TS), 1);
        end
        guard = 0;
        while (!oIsInitialized && guard < 500) begin
            tick();
            guard++;
        end
        chk("init_done", 32'(oIsInitialized), 1);
        chk("init_ready_together", 32'(oReady), 1);
        if (obs.size() >= 12) chk("idle_entry", cyc, obs[11].fall + T1640);
        exp_nib(1'b0, 4'h3, -1, -1);
        exp_nib(1'b0, 4'h3, T41 + TS, -1);
        exp_nib(1'b0, 4'h3, T100 + TS, -1);
        exp_nib(1'b0, 4'h2, T40 + TS, -1);
        exp_byte(1'b0, 8'h28, T40 + TS, -1);
        exp_byte(1'b0, 8'h06, T40 + TS, -1);
        exp_byte(1'b0, 8'h0C, T40 + TS, -1);
        exp_byte(1'b0, 8'h01, T40 + TS, -1);
        match_pulses("init");
    endtask

    // One write from IDLE. hold=1 leaves iWriteEnable high on return so the
    // next call is accepted immediately; hold=0 toggles it randomly while busy.
    task automatic write_byte(input logic [7:0] b, input bit hold);
        int acc, lat, early;
        nchar++;
        lat = LAT;
        iData = b;
        iWriteEnable = 1'b1;
        tick();
        acc = cyc;
        chk("ready_drop", 32'(oReady), 0);
        exp_byte(1'b1, b, -1, acc + 1 + TS);
        if (WRAP && (nchar % 16 == 0)) begin
            lat = lat + 2 * (TS + TE) + TG + T40;
            exp_byte(1'b0, (nchar % 32 == 0) ? 8'h80 : 8'hC0, T40 + TS, -1);
        end
        early = 0;
        for (int k = 1; k <= lat; k++) begin
            if (!hold) iWriteEnable = 1'($urandom_range(0, 1));
            iData = 8'($urandom);
            tick();
            if (k < lat && oReady) early++;
        end
        chk("busy_low", early, 0);
        chk("ready_return", 32'(oReady), 1);
        if (!hold) iWriteEnable = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_chk);
        $fatal(1);
    end

    initial begin
        bit   hold;
        int   guard;
        Reset = 1'b1;
        tick(); tick(); tick();

        do_init();

        write_byte(8'h41, 1'b0);
        repeat (20) tick();
        match_pulses("single");

        write_byte(8'h48, 1'b1);
        write_byte(8'h49, 1'b1);
        write_byte(8'h21, 1'b1);
        iWriteEnable = 1'b0;
        repeat (40) tick();
        match_pulses("held");

        iData = 8'hA5;
        iWriteEnable = 1'b1;
        tick();
        iWriteEnable = 1'b0;
        guard = 0;
        while (!oLCD_E && guard < 50) begin
            tick();
            guard++;
        end
        chk("e_before_reset", 32'(oLCD_E), 1);
        Reset = 1'b1;
        tick();
        chk("midreset_e", 32'(oLCD_E), 0);
        chk("midreset_ready", 32'(oReady), 0);
        chk("midreset_init", 32'(oIsInitialized), 0);
        do_init();

        for (int i = 0; i < 33; i++) begin
            hold = 1'($urandom_range(0, 1));
            write_byte(8'($urandom), hold);
            if (!hold || i == 32) begin
                iWriteEnable = 1'b0;
                repeat ($urandom_range(0, 5)) tick();
            end
        end
        iWriteEnable = 1'b0;
        repeat (60) tick();
        match_pulses("rand33");

        chk("setup_time", setup_short, 0);
        chk("bus_stable_while_e", bus_in_e, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
